// File: rtl/mist_frame_trig_if.sv
// Frame-trigger bundle: async video/download inputs in, frame count and dump-window status out.
interface mist_frame_trig_if;
    logic        vs;
    logic        downloading;
    logic [31:0] frame_cnt;
    logic        frame_pulse;
    logic        dump_en;
    logic        armed;
    logic        done;

    modport master (
        output vs,
        output downloading,
        input  frame_cnt,
        input  frame_pulse,
        input  dump_en,
        input  armed,
        input  done
    );

    modport slave (
        input  vs,
        input  downloading,
        output frame_cnt,
        output frame_pulse,
        output dump_en,
        output armed,
        output done
    );
endinterface

// File: rtl/mist_frame_trig.sv
// Purpose: synchronise vs/downloading into clk, count frames, open/close the dump window.
// Latency: frame_pulse and frame_cnt update on the 2nd clk edge after the edge that first samples vs low.
// Backpressure: none; frame_pulse is a 1-cycle strobe the consumer must sample every clk.
module mist_frame_trig #(
    parameter bit          LOADROM     = 1'b0,
    parameter logic [31:0] START_FRAME = 32'd0,
    parameter logic [31:0] STOP_FRAME  = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    mist_frame_trig_if.slave  bus
);
    localparam logic [1:0] ST_WAIT_LOAD = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_DUMPING   = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam logic [1:0] ST_INIT    = LOADROM ? ST_WAIT_LOAD :
                                        ((START_FRAME == 32'd0) ? ST_DUMPING : ST_ARMED);
    localparam bit         STOP_VALID = (STOP_FRAME > START_FRAME);

    logic        vs_s1, vs_s2, vs_d;
    logic        dl_s1, dl_s2, dl_d;
    logic        vs_fall, dl_fall, dl_rise;
    logic [1:0]  state_q, state_nxt;
    logic [31:0] cnt_q, cnt_nxt, cnt_inc;
    logic        pulse_q, pulse_nxt;
    logic        dump_en_q, armed_q, done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_d  <= 1'b0;
            dl_s1 <= 1'b0;
            dl_s2 <= 1'b0;
            dl_d  <= 1'b0;
        end else begin
            vs_s1 <= bus.vs;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
            dl_s1 <= bus.downloading;
            dl_s2 <= dl_s1;
            dl_d  <= dl_s2;
        end
    end

    // Download edges only matter when the trigger waits for a ROM load.
    assign vs_fall = vs_d & ~vs_s2;
    assign dl_fall = LOADROM & dl_d & ~dl_s2;
    assign dl_rise = LOADROM & ~dl_d & dl_s2;
    assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : (cnt_q + 32'd1);

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        pulse_nxt = 1'b0;
        if (dl_rise) begin
            state_nxt = ST_WAIT_LOAD;
            cnt_nxt   = 32'd0;
        end else if (state_q == ST_WAIT_LOAD) begin
            // A frame edge coinciding with the end of download is deliberately dropped.
            if (dl_fall) begin
                state_nxt = (START_FRAME == 32'd0) ? ST_DUMPING : ST_ARMED;
            end
        end else if (vs_fall) begin
            pulse_nxt = 1'b1;
            cnt_nxt   = cnt_inc;
            if ((state_q == ST_ARMED) && (cnt_inc == START_FRAME)) begin
                state_nxt = ST_DUMPING;
            end
            if ((state_q == ST_DUMPING) && STOP_VALID && (cnt_inc == STOP_FRAME)) begin
                state_nxt = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= 32'd0;
            pulse_q   <= 1'b0;
            dump_en_q <= 1'b0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            pulse_q   <= pulse_nxt;
            dump_en_q <= (state_nxt == ST_DUMPING);
            armed_q   <= (state_nxt == ST_ARMED) || (state_nxt == ST_DUMPING);
            done_q    <= (state_nxt == ST_DONE);
        end
    end

    assign bus.frame_cnt   = cnt_q;
    assign bus.frame_pulse = pulse_q;
    assign bus.dump_en     = dump_en_q;
    assign bus.armed       = armed_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_mist_frame_trig.sv
// Four trigger configurations share one vs/downloading stimulus; each is checked every cycle
// against a frame-counting reference model plus directed constant checks.
module tb_mist_frame_trig;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs = 1'b1;
    logic downloading = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cnt;
        logic        pulse;
        logic        en;
        logic        armed;
        logic        done;
    } obs_t;

    // Configurations: a=(0,3,5) b=(1,2,0) c=(1,0,0) d=(0,0,2) as (LOADROM,START,STOP)
    localparam logic [3:0] P_LOAD      = 4'b0110;
    localparam int         P_START [4] = '{3, 2, 0, 0};
    localparam int         P_STOP  [4] = '{5, 0, 0, 2};

    mist_frame_trig_if if_a ();
    mist_frame_trig_if if_b ();
    mist_frame_trig_if if_c ();
    mist_frame_trig_if if_d ();

    assign if_a.vs = vs;  assign if_a.downloading = downloading;
    assign if_b.vs = vs;  assign if_b.downloading = downloading;
    assign if_c.vs = vs;  assign if_c.downloading = downloading;
    assign if_d.vs = vs;  assign if_d.downloading = downloading;

    mist_frame_trig #(.LOADROM(1'b0), .START_FRAME(32'd3), .STOP_FRAME(32'd5))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    mist_frame_trig #(.LOADROM(1'b1), .START_FRAME(32'd2), .STOP_FRAME(32'd0))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    mist_frame_trig #(.LOADROM(1'b1), .START_FRAME(32'd0), .STOP_FRAME(32'd0))
        u_c (.clk(clk), .rst(rst), .bus(if_c));
    mist_frame_trig #(.LOADROM(1'b0), .START_FRAME(32'd0), .STOP_FRAME(32'd2))
        u_d (.clk(clk), .rst(rst), .bus(if_d));

    // Reference model: sample history plus per-config loading/started/stopped flags.
    bit          vq[$];
    bit          dq[$];
    logic        m_load [4];
    logic [31:0] m_cnt  [4];
    logic        m_go   [4];
    logic        m_stop [4];
    obs_t        m_out  [4];

    function automatic obs_t dut_obs(input int i);
        obs_t o;
        case (i)
            0:       o = {if_a.frame_cnt, if_a.frame_pulse, if_a.dump_en, if_a.armed, if_a.done};
            1:       o = {if_b.frame_cnt, if_b.frame_pulse, if_b.dump_en, if_b.armed, if_b.done};
            2:       o = {if_c.frame_cnt, if_c.frame_pulse, if_c.dump_en, if_c.armed, if_c.done};
            default: o = {if_d.frame_cnt, if_d.frame_pulse, if_d.dump_en, if_d.armed, if_d.done};
        endcase
        return o;
    endfunction

    task automatic model_reset();
        vq = {1'b0, 1'b0, 1'b0};
        dq = {1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            m_load[i] = P_LOAD[i];
            m_cnt[i]  = 32'd0;
            m_go[i]   = !P_LOAD[i] && (P_START[i] == 0);
            m_stop[i] = 1'b0;
            m_out[i]  = '0;
        end
    endtask

    task automatic model_step(input bit v, input bit dl);
        bit vf, df, dr, pl;
        vf = vq[0] && !vq[1];
        df = dq[0] && !dq[1];
        dr = !dq[0] && dq[1];
        vq.push_back(v);
        void'(vq.pop_front());
        dq.push_back(dl);
        void'(dq.pop_front());
        for (int i = 0; i < 4; i++) begin
            pl = 1'b0;
            if (P_LOAD[i] && dr) begin
                m_load[i] = 1'b1;
                m_cnt[i]  = 32'd0;
                m_go[i]   = 1'b0;
                m_stop[i] = 1'b0;
            end else if (m_load[i]) begin
                if (df) begin
                    m_load[i] = 1'b0;
                    m_go[i]   = (P_START[i] == 0);
                end
            end else if (vf) begin
                pl = 1'b1;
                if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
                if (m_go[i] && (P_STOP[i] > P_START[i]) && (m_cnt[i] == P_STOP[i]))
                    m_stop[i] = 1'b1;
                else if (!m_go[i] && (m_cnt[i] == P_START[i]))
                    m_go[i] = 1'b1;
            end
            m_out[i] = {m_cnt[i], pl, !m_load[i] && m_go[i] && !m_stop[i],
                        !m_load[i] && !m_stop[i], m_stop[i]};
        end
    endtask

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(vs, downloading);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            assert (dut_obs(i) === m_out[i]) else begin
                errors++;
                $error("FAIL model_dut%0d {cnt,pulse,en,armed,done} got %h expected %h",
                       i, dut_obs(i), m_out[i]);
            end
        end
    endtask

    // Entered 1 time unit after a rising edge, so vs falls 2 units after that edge.
    task automatic frame(input logic [31:0] a_cnt);
        #1 vs = 1'b0;
        tick();
        tick();
        chk("lat_early", 36'(if_a.frame_pulse), 36'd0);
        tick();
        chk("lat_pulse", 36'(if_a.frame_pulse), 36'd1);
        chk("a_cnt", 36'(if_a.frame_cnt), 36'(a_cnt));
        tick();
        chk("lat_width", 36'(if_a.frame_pulse), 36'd0);
        #1 vs = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        model_reset();
        #2;
        for (int i = 0; i < 4; i++) chk("reset_vals", dut_obs(i), 36'd0);
        #10 rst = 1'b0;
        tick();
        chk("d_en_first_cycle", 36'(if_d.dump_en), 36'd1);
        chk("a_armed", 36'(if_a.armed), 36'd1);
        chk("a_en_before_start", 36'(if_a.dump_en), 36'd0);
        chk("b_wait_load", 36'(if_b.armed), 36'd0);
        repeat (2) tick();

        for (int k = 1; k <= 6; k++) begin
            frame(32'(k));
            chk("a_window", 36'(if_a.dump_en), 36'((k >= 3) && (k < 5)));
            chk("a_done", 36'(if_a.done), 36'(k >= 5));
        end
        chk("b_held_zero", 36'(if_b.frame_cnt), 36'd0);

        #1 downloading = 1'b1;
        repeat (4) tick();
        for (int k = 7; k <= 10; k++) frame(32'(k));
        chk("b_cnt_during_dl", 36'(if_b.frame_cnt), 36'd0);
        #1 downloading = 1'b0;
        repeat (4) tick();
        chk("b_armed_after_dl", 36'(if_b.armed), 36'd1);
        chk("c_en_after_dl", 36'(if_c.dump_en), 36'd1);
        frame(32'd11);
        chk("b_first_frame", 36'(if_b.frame_cnt), 36'd1);

        for (int k = 12; k <= 14; k++) frame(32'(k));
        chk("b_cnt_mid", 36'(if_b.frame_cnt), 36'd4);
        chk("b_en_mid", 36'(if_b.dump_en), 36'd1);
        #1 downloading = 1'b1;
        repeat (4) tick();
        chk("reload_en", 36'(if_b.dump_en), 36'd0);
        chk("reload_cnt", 36'(if_b.frame_cnt), 36'd0);
        chk("reload_armed", 36'(if_b.armed), 36'd0);
        #1 downloading = 1'b0;
        repeat (4) tick();
        frame(32'd15);
        frame(32'd16);
        chk("reload_b_cnt", 36'(if_b.frame_cnt), 36'd2);
        chk("reload_b_en", 36'(if_b.dump_en), 36'd1);

        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) chk("async_rst", dut_obs(i), 36'd0);
        model_reset();
        rst = 1'b0;
        repeat (3) tick();
        chk("a_cnt_after_rst", 36'(if_a.frame_cnt), 36'd0);

        force u_a.cnt_q = 32'hFFFF_FFFE;
        m_cnt[0] = 32'hFFFF_FFFE;
        tick();
        release u_a.cnt_q;
        chk("sat_preload", 36'(if_a.frame_cnt), 36'hFFFF_FFFE);
        repeat (3) frame(32'hFFFF_FFFF);

        #1 downloading = 1'b1;
        repeat (4) tick();
        #1 begin downloading = 1'b0; vs = 1'b0; end
        repeat (5) tick();
        chk("simul_fall_cnt", 36'(if_b.frame_cnt), 36'd0);
        chk("simul_fall_armed", 36'(if_b.armed), 36'd1);
        chk("simul_fall_c_cnt", 36'(if_c.frame_cnt), 36'd0);
        #1 vs = 1'b1;
        repeat (3) tick();
        #1 begin downloading = 1'b1; vs = 1'b0; end
        repeat (5) tick();
        chk("simul_rise_armed", 36'(if_b.armed), 36'd0);
        chk("simul_rise_c_cnt", 36'(if_c.frame_cnt), 36'd0);
        #1 begin downloading = 1'b0; vs = 1'b1; end
        repeat (4) tick();

        for (int n = 0; n < 1500; n++) begin
            #($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) vs = ~vs;
            if ($urandom_range(0, 19) == 0) begin
                vs = ~vs;
                #1 vs = ~vs;
            end
            if ($urandom_range(0, 39) == 0) downloading = ~downloading;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
